// File: rtl/gf3_ram_if.sv
// Host and engine access bundle for the GF(3^m) operand RAM.
// The master side drives addresses and write data; the slave side returns registered reads and ready.
interface gf3_ram_if #(
    parameter int WIDTH = 198,
    parameter int AW    = 6
);
    logic             sel;
    logic [AW-1:0]    addr;
    logic             w;
    logic [WIDTH-1:0] data;
    logic [WIDTH-1:0] out;
    logic [AW-1:0]    ea;
    logic [AW-1:0]    eb;
    logic             ew;
    logic [AW-1:0]    ewa;
    logic [WIDTH-1:0] ewd;
    logic [WIDTH-1:0] outa;
    logic [WIDTH-1:0] outb;
    logic             ready;

    modport master (
        output sel, addr, w, data, ea, eb, ew, ewa, ewd,
        input  out, outa, outb, ready
    );

    modport slave (
        input  sel, addr, w, data, ea, eb, ew, ewa, ewd,
        output out, outa, outb, ready
    );
endinterface

// File: rtl/gf3_ram.sv
// Operand RAM for the pairing core: one host port and one engine port share a single array.
// After reset a sweep zeroes every word, and only then is ready raised.
module gf3_ram #(
    parameter int WIDTH         = 198,
    parameter int DEPTH         = 64,
    parameter int AW            = 6,
    parameter int INIT_ON_RESET = 1
) (
    input  logic      clk,
    input  logic      reset,
    gf3_ram_if.slave  bus
);
    typedef enum logic {INIT, READY} state_t;

    state_t           state, state_nx;
    logic [AW-1:0]    cnt, cnt_nx;
    logic             rdy;
    logic [WIDTH-1:0] mem [DEPTH];

    // The owner's write, after ownership, ready and range gating
    logic             we;
    logic [AW-1:0]    wa;
    logic [WIDTH-1:0] wd;

    logic             mem_we;
    logic [AW-1:0]    mem_wa;
    logic [WIDTH-1:0] mem_wd;

    logic [WIDTH-1:0] rd_h, rd_a, rd_b;
    logic [WIDTH-1:0] out_q, outa_q, outb_q;

    function automatic logic in_range(input logic [AW-1:0] a);
        return int'(a) < DEPTH;
    endfunction

    // Write-first: a port that reads the address being written sees the new data
    function automatic logic [WIDTH-1:0] rd(input logic [AW-1:0] a);
        if (!in_range(a))
            return '0;
        if (we && a == wa)
            return wd;
        return mem[a];
    endfunction

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        if (state == INIT) begin
            cnt_nx = cnt + 1'b1;
            if (int'(cnt) == DEPTH - 1)
                state_nx = READY;
        end
    end

    always_comb begin
        we = 1'b0;
        wa = bus.ewa;
        wd = bus.ewd;
        if (rdy) begin
            if (bus.sel) begin
                we = bus.w & in_range(bus.addr);
                wa = bus.addr;
                wd = bus.data;
            end else begin
                we = bus.ew & in_range(bus.ewa);
            end
        end
        mem_we = we;
        mem_wa = wa;
        mem_wd = wd;
        // rdy is low throughout the sweep, so the two write sources never overlap
        if (state == INIT && !reset) begin
            mem_we = 1'b1;
            mem_wa = cnt;
            mem_wd = '0;
        end
    end

    always_comb begin
        rd_h = rd(bus.addr);
        rd_a = rd(bus.ea);
        rd_b = rd(bus.eb);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= (INIT_ON_RESET != 0) ? INIT : READY;
            cnt    <= '0;
            rdy    <= 1'b0;
            out_q  <= '0;
            outa_q <= '0;
            outb_q <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            rdy   <= (state_nx == READY);
            if (rdy) begin
                out_q  <= rd_h;
                outa_q <= rd_a;
                outb_q <= rd_b;
            end else begin
                out_q  <= '0;
                outa_q <= '0;
                outb_q <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we)
            mem[mem_wa] <= mem_wd;
    end

    assign bus.out   = out_q;
    assign bus.outa  = outa_q;
    assign bus.outb  = outb_q;
    assign bus.ready = rdy;
endmodule

// File: tb/tb_gf3_ram.sv
// Scoreboard bench for gf3_ram: three instances (64 words with clear, 40 words with clear, 64 words without clear).
// Stimulus queues expected port values tagged with a cycle; a negedge monitor compares them.
module tb_gf3_ram;
    localparam int W = 198;

    typedef struct packed {
        logic         sel;
        logic [5:0]   addr;
        logic         w;
        logic [W-1:0] data;
        logic [5:0]   ea;
        logic [5:0]   eb;
        logic         ew;
        logic [5:0]   ewa;
        logic [W-1:0] ewd;
    } req_t;

    typedef struct packed {
        logic [W-1:0] out;
        logic [W-1:0] outa;
        logic [W-1:0] outb;
        logic         ready;
    } rsp_t;

    typedef struct {
        int           cyc;
        int           d;
        int           p;
        logic [W-1:0] v;
        string        tag;
    } exp_t;

    localparam int P_OUT = 0, P_A = 1, P_B = 2, P_RDY = 3;

    logic clk = 1'b0;
    logic rst0, rst1, rst2;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    req_t rq [3];
    rsp_t rs [3];
    exp_t sb [$];
    logic [W-1:0] mon_got;

    logic [W-1:0] va, vb, v2, v2a, ones;
    int r0, r1, r2;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    gf3_ram_if #(.WIDTH(W), .AW(6)) b0 ();
    gf3_ram_if #(.WIDTH(W), .AW(6)) b1 ();
    gf3_ram_if #(.WIDTH(W), .AW(6)) b2 ();

    assign {b0.sel, b0.addr, b0.w, b0.data, b0.ea, b0.eb, b0.ew, b0.ewa, b0.ewd} = rq[0];
    assign {b1.sel, b1.addr, b1.w, b1.data, b1.ea, b1.eb, b1.ew, b1.ewa, b1.ewd} = rq[1];
    assign {b2.sel, b2.addr, b2.w, b2.data, b2.ea, b2.eb, b2.ew, b2.ewa, b2.ewd} = rq[2];
    assign rs[0] = {b0.out, b0.outa, b0.outb, b0.ready};
    assign rs[1] = {b1.out, b1.outa, b1.outb, b1.ready};
    assign rs[2] = {b2.out, b2.outa, b2.outb, b2.ready};

    gf3_ram #(.WIDTH(W), .DEPTH(64), .AW(6), .INIT_ON_RESET(1)) u0 (.clk(clk), .reset(rst0), .bus(b0));
    gf3_ram #(.WIDTH(W), .DEPTH(40), .AW(6), .INIT_ON_RESET(1)) u1 (.clk(clk), .reset(rst1), .bus(b1));
    gf3_ram #(.WIDTH(W), .DEPTH(64), .AW(6), .INIT_ON_RESET(0)) u2 (.clk(clk), .reset(rst2), .bus(b2));

    function automatic logic [W-1:0] pick(input rsp_t r, input int p);
        case (p)
            P_OUT:   return r.out;
            P_A:     return r.outa;
            P_B:     return r.outb;
            default: return {{(W-1){1'b0}}, r.ready};
        endcase
    endfunction

    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
                checks++;
                mon_got = pick(rs[sb[i].d], sb[i].p);
                if (mon_got !== sb[i].v) begin
                    failures++;
                    $display("FAIL %s dut%0d port%0d cyc%0d got %h want %h",
                             sb[i].tag, sb[i].d, sb[i].p, cyc, mon_got, sb[i].v);
                end
                sb.delete(i);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ex(input int c, input int d, input int p, input logic [W-1:0] v, input string t);
        exp_t e;
        e.cyc = c; e.d = d; e.p = p; e.v = v; e.tag = t;
        sb.push_back(e);
    endtask

    task automatic nx(input int d, input int p, input logic [W-1:0] v, input string t);
        ex(cyc + 1, d, p, v, t);
    endtask

    task automatic op(input int d, input logic s, input logic hw, input logic [5:0] a,
                      input logic [W-1:0] dat, input logic e_w, input logic [5:0] e_wa,
                      input logic [W-1:0] e_wd, input logic [5:0] e_a, input logic [5:0] e_b);
        rq[d] = '{sel: s, addr: a, w: hw, data: dat, ea: e_a, eb: e_b, ew: e_w, ewa: e_wa, ewd: e_wd};
        step();
    endtask

    initial begin
        va   = 198'h115a25886512165251569195908560596a6695612620504191;
        vb   = 198'h1559546442405a181195655549614540592955a15a26984015;
        v2   = {2'b01, {49{4'h2}}};
        v2a  = {2'b10, {49{4'ha}}};
        ones = '1;
        for (int i = 0; i < 3; i++) rq[i] = '0;
        rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
        step(); step();

        // DEPTH=64 clear sweep
        r0 = cyc; rst0 = 1'b0;
        ex(r0, 0, P_RDY, '0, "rst_ready");
        ex(r0, 0, P_OUT, '0, "rst_out");
        ex(r0, 0, P_A, '0, "rst_outa");
        ex(r0 + 63, 0, P_RDY, '0, "sweep_ready_low");
        ex(r0 + 64, 0, P_RDY, 1, "sweep_ready_high");
        repeat (20) step();
        nx(0, P_OUT, '0, "sweep_out_zero");
        op(0, 1, 1, 2, va, 0, 0, '0, 0, 0);
        rq[0] = '0;
        for (int k = 0; k < 100 && cyc < r0 + 64; k++) step();

        nx(0, P_OUT, '0, "clear_0");   op(0, 1, 0, 0,  '0, 0, 0, '0, 0, 0);
        nx(0, P_OUT, '0, "clear_37");  op(0, 1, 0, 37, '0, 0, 0, '0, 0, 0);
        nx(0, P_OUT, '0, "clear_63");  op(0, 1, 0, 63, '0, 0, 0, '0, 0, 0);
        nx(0, P_OUT, '0, "sweep_wr_ignored"); op(0, 1, 0, 2, '0, 0, 0, '0, 0, 0);

        // Host write/read
        nx(0, P_OUT, va, "host_wr0_bypass"); nx(0, P_A, va, "host_wr0_outa");
        op(0, 1, 1, 0, va, 0, 0, '0, 0, 0);
        nx(0, P_OUT, vb, "host_wr3_bypass");
        op(0, 1, 1, 3, vb, 0, 0, '0, 0, 0);
        nx(0, P_OUT, vb, "host_w0_nowrite");
        op(0, 1, 0, 3, v2, 0, 0, '0, 0, 0);
        nx(0, P_OUT, va, "host_rd0");  op(0, 1, 0, 0, '0, 0, 0, '0, 0, 0);
        nx(0, P_OUT, vb, "host_rd3");  op(0, 1, 0, 3, '0, 0, 0, '0, 0, 0);

        // Ownership
        nx(0, P_A, '0, "eng_wr_nonowner");
        op(0, 1, 0, 0, '0, 1, 5, ones, 5, 0);
        nx(0, P_A, '0, "eng_rd5_after_ignored"); nx(0, P_B, '0, "host_wr_nonowner");
        op(0, 0, 1, 6, va, 0, 0, '0, 5, 6);
        nx(0, P_A, '0, "rd6_stays_zero");
        op(0, 0, 0, 6, '0, 0, 0, '0, 6, 0);
        nx(0, P_A, ones, "eng_wr5_bypass"); nx(0, P_B, va, "eng_rd0");
        op(0, 0, 0, 0, '0, 1, 5, ones, 5, 0);
        nx(0, P_A, ones, "eng_rd5_stored"); nx(0, P_OUT, ones, "host_rd5");
        op(0, 0, 0, 5, '0, 0, 0, '0, 5, 0);

        // Write-first bypass
        op(0, 0, 0, 0, '0, 1, 8, vb, 0, 0);
        nx(0, P_OUT, v2a, "byp_out"); nx(0, P_A, v2a, "byp_outa"); nx(0, P_B, v2a, "byp_outb");
        op(0, 0, 0, 9, '0, 1, 9, v2a, 9, 9);
        nx(0, P_A, vb, "byp_other_old"); nx(0, P_B, ones, "byp_outb2"); nx(0, P_OUT, ones, "byp_out2");
        op(0, 0, 0, 9, '0, 1, 9, ones, 8, 9);
        nx(0, P_A, ones, "rd9_stored"); nx(0, P_B, vb, "rd8_stored");
        op(0, 0, 0, 0, '0, 0, 0, '0, 9, 8);
        rq[0] = '0;

        // DEPTH=40: reset mid-sweep and out-of-range addresses
        r1 = cyc; rst1 = 1'b0;
        repeat (20) step();
        ex(cyc, 1, P_RDY, '0, "d40_mid_sweep_ready");
        rst1 = 1'b1; step();
        r1 = cyc; rst1 = 1'b0;
        ex(r1 + 39, 1, P_RDY, '0, "d40_restart_low");
        ex(r1 + 40, 1, P_RDY, 1, "d40_restart_high");
        for (int k = 0; k < 100 && cyc < r1 + 40; k++) step();
        nx(1, P_OUT, '0, "d40_rd39_clear");  op(1, 1, 0, 39, '0, 0, 0, '0, 0, 0);
        op(1, 1, 1, 10, va, 0, 0, '0, 0, 0);
        nx(1, P_OUT, '0, "d40_oor_wr_out"); nx(1, P_A, '0, "d40_oor_wr_outa");
        op(1, 1, 1, 50, vb, 0, 0, '0, 50, 10);
        nx(1, P_OUT, '0, "d40_oor_rd");     op(1, 1, 0, 50, '0, 0, 0, '0, 0, 0);
        nx(1, P_OUT, va, "d40_no_wrap");    op(1, 1, 0, 10, '0, 0, 0, '0, 0, 0);
        rq[1] = '0;

        // No clear sweep
        r2 = cyc; rst2 = 1'b0;
        ex(r2, 2, P_RDY, '0, "noinit_rst_ready");
        ex(r2 + 1, 2, P_RDY, 1, "noinit_ready");
        step();
        nx(2, P_OUT, vb, "noinit_wr63");  op(2, 1, 1, 63, vb, 0, 0, '0, 0, 0);
        nx(2, P_OUT, vb, "noinit_rd63");  op(2, 1, 0, 63, '0, 0, 0, '0, 0, 0);
        rq[2] = '0;

        step(); step();
        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_drain left %0d want 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
